arb_mux_ctrl: RTL and testbench
===============================

ARB_MUX_CTRL -- requirements
Module: arb_mux_ctrl

Interface
REQ-001 Parameter: BITNUMBER, 6, word width; bit BITNUMBER-2 is the class bit (1 = D1, 0 = D0), bit BITNUMBER-1 and low bits are payload.
REQ-002 Parameter: NPORT, 4, number of input FIFOs (fixed at 4 for this revision).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = arbitration allowed; 0 = finish nothing new, hold pointer.
REQ-006 fifo_empty_P[3:0]  input  4  empty flag of each first-word-fall-through input FIFO.
REQ-007 data_P0..data_P3  input  BITNUMBER each  head word of each input FIFO, valid whenever its empty flag is 0.
REQ-008 almost_full_D0, almost_full_D1  input  1 each  downstream FIFO back-pressure.
REQ-009 pop_P[3:0]  output  4  one-hot (or zero) pop to input FIFOs, combinational from registered state and current inputs.
REQ-010 Mux_out  output  BITNUMBER  registered forwarded word.
REQ-011 Mux_valid  output  1  registered qualifier for Mux_out.
REQ-012 idle  output  1  registered; 1 when state is IDLE.
REQ-013 count_P0..count_P3  output  8 each  registered words-forwarded counters.

Function
REQ-014 States: INIT, IDLE, ACTIVE; reset enters INIT.
REQ-015 INIT -> IDLE unconditionally after one clock.
REQ-016 IDLE -> ACTIVE when enable=1 and at least one port is eligible; else stay IDLE.
REQ-017 ACTIVE -> IDLE when enable=0 or no port is eligible in that cycle; no pop in the cycle of that decision.
REQ-018 Port p eligible when fifo_empty_P[p]=0 and the almost_full flag of the destination selected by data_Pp[BITNUMBER-2] is 0.
REQ-019 Round-robin: search starts at ptr, ptr+1, ... mod 4; first eligible port is granted; ptr <= granted+1 mod 4 (3 wraps to 0).
REQ-020 At most one pop_P bit high per cycle; pops only in ACTIVE with enable=1.
REQ-021 Latency: word popped in cycle N appears on Mux_out with Mux_valid=1 in cycle N+1 (one register stage).
REQ-022 Cycle with no pop: Mux_valid=0 and Mux_out=0 next cycle.
REQ-023 Ineligible head (destination almost full) is skipped, not stalled on; other eligible ports proceed (no head-of-line blocking across ports).
REQ-024 Both almost_full flags high: no pops, state -> IDLE.
REQ-025 count_Pp increments by 1 on each pop of port p, wraps 255 -> 0; no saturation.
REQ-026 enable deasserted: ptr and counters hold; the word popped in the previous cycle is still delivered.
REQ-027 Throughput: one word per clock sustained when eligible ports exist.

Reset
REQ-028 Asynchronous assertion clears state to INIT, ptr to 0, Mux_out to 0, Mux_valid to 0, idle to 0, all counters to 0.
REQ-029 pop_P is 0 while reset is high and in INIT.
REQ-030 Reset mid-operation discards any registered word (Mux_valid=0); no pop issued in the reset-release cycle.

Structure
REQ-031 Shared package holds state encoding (INIT=2'd0, IDLE=2'd1, ACTIVE=2'd2), NPORT, counter width 8, class-bit index BITNUMBER-2.
REQ-032 One sub-module: rr_grant4 (combinational: eligible[3:0], ptr[1:0] -> grant one-hot, grant index, any).
REQ-033 Output stage feeds demux_t directly (Mux_out, Mux_valid); no extra pipeline.

Verification
REQ-034 Reset then idle: all FIFOs empty -> INIT one cycle, then idle=1, pop_P=0, Mux_valid=0.
REQ-035 All four ports non-empty, class bit 0, no back-pressure, enable=1 -> pops P0,P1,P2,P3,P0 on consecutive cycles; Mux_out matches each head one cycle later; count_Px each =1 after four cycles.
REQ-036 P0 head 6'b010101 (D1), almost_full_D1=1, P1 head 6'b000011 (D0) -> P0 skipped, P1 popped, Mux_out=6'b000011 next cycle.
REQ-037 Both almost_full=1 with non-empty ports -> pop_P=0, state IDLE; release almost_full_D0 -> pops resume from ptr.
REQ-038 Only P2 non-empty for 256 pops -> count_P2 wraps to 0, others 0.
REQ-039 Assert reset mid-stream (asynchronously, between edges) -> Mux_valid and counters 0 immediately, pop_P=0, restart in INIT with ptr=0.

Source files
------------

// File: rtl/arb_mux_ctrl_pkg.sv
// Shared definitions for the four-port arbitrating mux controller.
// State encoding, widths and small pointer helpers.
package arb_mux_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam int NPORT_C = 4;
  localparam int CNT_W   = 8;

  // Position of the destination class bit inside a word.
  function automatic int class_bit(input int bitnumber);
    return bitnumber - 2;
  endfunction

  // Round-robin successor; 3 wraps to 0 via 2-bit overflow.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/arb_mux_ctrl_rr_grant4.sv
// Combinational 4-way round-robin grant.
// Search begins at i_ptr and wraps modulo 4.
module rr_grant4 (
  input  logic [3:0] i_eligible,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_grant,
  output logic [1:0] o_idx,
  output logic       o_any
);

  logic [3:0] w_rot;
  logic [1:0] w_off;

  // Rotate so bit 0 is the port at i_ptr, then take the lowest set bit.
  always_comb begin
    w_rot = 4'b0000;
    w_off = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_rot[k] = i_eligible[i_ptr + 2'(k)];
    end
    for (int k = 3; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = 2'(k);
      end
    end
  end

  assign o_any   = |i_eligible;
  assign o_idx   = i_ptr + w_off;
  assign o_grant = o_any ? (4'b0001 << o_idx) : 4'b0000;

endmodule

// File: rtl/arb_mux_ctrl.sv
// Arbitrating mux: round-robin pops from four FWFT FIFOs, skipping
// heads whose destination is almost full; one registered output word.
module arb_mux_ctrl
  import arb_mux_ctrl_pkg::*;
#(
  parameter int BITNUMBER = 6,
  parameter int NPORT     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NPORT-1:0]     fifo_empty_P,
  input  logic [BITNUMBER-1:0] data_P0,
  input  logic [BITNUMBER-1:0] data_P1,
  input  logic [BITNUMBER-1:0] data_P2,
  input  logic [BITNUMBER-1:0] data_P3,
  input  logic                 almost_full_D0,
  input  logic                 almost_full_D1,
  output logic [NPORT-1:0]     pop_P,
  output logic [BITNUMBER-1:0] Mux_out,
  output logic                 Mux_valid,
  output logic                 idle,
  output logic [CNT_W-1:0]     count_P0,
  output logic [CNT_W-1:0]     count_P1,
  output logic [CNT_W-1:0]     count_P2,
  output logic [CNT_W-1:0]     count_P3
);

  localparam int CB = class_bit(BITNUMBER);

  state_t               r_state;
  logic [1:0]           r_ptr;
  logic [BITNUMBER-1:0] r_out;
  logic                 r_valid;
  logic                 r_idle;
  logic [CNT_W-1:0]     r_cnt [NPORT];

  logic [BITNUMBER-1:0] w_data [NPORT];
  logic [NPORT-1:0]     w_elig;
  logic [NPORT-1:0]     w_grant;
  logic [1:0]           w_idx;
  logic                 w_any;
  logic                 w_fire;

  assign w_data[0] = data_P0;
  assign w_data[1] = data_P1;
  assign w_data[2] = data_P2;
  assign w_data[3] = data_P3;

  // A head is eligible when present and its destination has room.
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < NPORT; p++) begin
      w_elig[p] = !fifo_empty_P[p] &&
                  !(w_data[p][CB] ? almost_full_D1
                                  : almost_full_D0);
    end
  end

  rr_grant4 u_grant (
    .i_eligible (w_elig),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_idx      (w_idx),
    .o_any      (w_any)
  );

  assign w_fire = (r_state == ST_ACTIVE) && enable && w_any;
  assign pop_P  = w_fire ? w_grant : '0;

  // Control FSM with registered word, qualifier, idle flag and pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_ptr   <= 2'd0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_idle  <= 1'b0;
    end else begin
      r_valid <= w_fire;
      r_out   <= w_fire ? w_data[w_idx] : '0;
      unique case (r_state)
        ST_INIT: begin
          r_state <= ST_IDLE;
          r_idle  <= 1'b1;
        end
        ST_IDLE: begin
          if (enable && w_any) begin
            r_state <= ST_ACTIVE;
            r_idle  <= 1'b0;
          end else begin
            r_idle  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_fire) begin
            r_ptr   <= rr_next(w_idx);
          end else begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_idle  <= 1'b0;
        end
      endcase
    end
  end

  // Per-port forwarded-word counters, free-running modulo 256.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NPORT; p++) begin
        r_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (pop_P[p]) begin
          r_cnt[p] <= r_cnt[p] + 1'b1;
        end
      end
    end
  end

  assign Mux_out   = r_out;
  assign Mux_valid = r_valid;
  assign idle      = r_idle;
  assign count_P0  = r_cnt[0];
  assign count_P1  = r_cnt[1];
  assign count_P2  = r_cnt[2];
  assign count_P3  = r_cnt[3];

endmodule

// File: tb/tb_arb_mux_ctrl.sv
// Directed bench for arb_mux_ctrl with a queue model of the input FIFOs.
// Expected values are hand-computed constants.
module tb_arb_mux_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] fifo_empty_P = 4'hF;
  logic [5:0] data_P0 = '0;
  logic [5:0] data_P1 = '0;
  logic [5:0] data_P2 = '0;
  logic [5:0] data_P3 = '0;
  logic       almost_full_D0 = 1'b0;
  logic       almost_full_D1 = 1'b0;
  logic [3:0] pop_P;
  logic [5:0] Mux_out;
  logic       Mux_valid;
  logic       idle;
  logic [7:0] count_P0, count_P1;
  logic [7:0] count_P2, count_P3;

  arb_mux_ctrl #(.BITNUMBER(6), .NPORT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .fifo_empty_P   (fifo_empty_P),
    .data_P0        (data_P0),
    .data_P1        (data_P1),
    .data_P2        (data_P2),
    .data_P3        (data_P3),
    .almost_full_D0 (almost_full_D0),
    .almost_full_D1 (almost_full_D1),
    .pop_P          (pop_P),
    .Mux_out        (Mux_out),
    .Mux_valid      (Mux_valid),
    .idle           (idle),
    .count_P0       (count_P0),
    .count_P1       (count_P1),
    .count_P2       (count_P2),
    .count_P3       (count_P3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_pops = 0;
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc = -1;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] q2[$];
  logic [5:0] q3[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    fifo_empty_P[0] = (q0.size() == 0);
    fifo_empty_P[1] = (q1.size() == 0);
    fifo_empty_P[2] = (q2.size() == 0);
    fifo_empty_P[3] = (q3.size() == 0);
    data_P0 = (q0.size() != 0) ? q0[0] : 6'd0;
    data_P1 = (q1.size() != 0) ? q1[0] : 6'd0;
    data_P2 = (q2.size() != 0) ? q2[0] : 6'd0;
    data_P3 = (q3.size() != 0) ? q3[0] : 6'd0;
    #1;
  endtask

  task automatic step();
    logic [3:0] p;
    p = pop_P;
    @(posedge clk);
    #1;
    cyc++;
    if (p[0] && q0.size() != 0) void'(q0.pop_front());
    if (p[1] && q1.size() != 0) void'(q1.pop_front());
    if (p[2] && q2.size() != 0) void'(q2.pop_front());
    if (p[3] && q3.size() != 0) void'(q3.pop_front());
    if (p != 4'd0) begin
      n_pops++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    settle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int budget;
    bit seen255;

    // Reset and idle with all FIFOs empty
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pop", pop_P, 4'h0);
    chk("rst_valid", Mux_valid, 1'b0);
    chk("rst_out", Mux_out, 6'h00);
    chk("rst_idle", idle, 1'b0);
    chk("rst_cnt0", count_P0, 8'd0);
    chk("rst_cnt3", count_P3, 8'd0);
    reset = 1'b0;
    settle();
    chk("init_pop", pop_P, 4'h0);
    step();
    chk("idle_flag", idle, 1'b1);
    chk("idle_pop", pop_P, 4'h0);
    chk("idle_valid", Mux_valid, 1'b0);

    // Round-robin over four busy ports
    q0.push_back(6'h01); q0.push_back(6'h05);
    q1.push_back(6'h02);
    q2.push_back(6'h03);
    q3.push_back(6'h04);
    settle();
    chk("rr_idle_nopop", pop_P, 4'h0);
    step();
    chk("rr_act_idle", idle, 1'b0);
    chk("rr_pop0", pop_P, 4'b0001);
    step();
    chk("rr_out1", Mux_out, 6'h01);
    chk("rr_val1", Mux_valid, 1'b1);
    chk("rr_pop1", pop_P, 4'b0010);
    step();
    chk("rr_out2", Mux_out, 6'h02);
    chk("rr_pop2", pop_P, 4'b0100);
    step();
    chk("rr_out3", Mux_out, 6'h03);
    chk("rr_pop3", pop_P, 4'b1000);
    step();
    chk("rr_out4", Mux_out, 6'h04);
    chk("rr_pop0b", pop_P, 4'b0001);
    chk("rr_cnt0", count_P0, 8'd1);
    chk("rr_cnt1", count_P1, 8'd1);
    chk("rr_cnt2", count_P2, 8'd1);
    chk("rr_cnt3", count_P3, 8'd1);
    step();
    chk("rr_out5", Mux_out, 6'h05);
    chk("rr_nopop", pop_P, 4'h0);
    chk("rr_cnt0b", count_P0, 8'd2);
    step();
    chk("rr_drain_val", Mux_valid, 1'b0);
    chk("rr_drain_out", Mux_out, 6'h00);
    chk("rr_drain_idle", idle, 1'b1);

    // Move pointer to 0, then skip a blocked D1 head
    q3.push_back(6'h07);
    settle();
    chk("pre_nopop", pop_P, 4'h0);
    step();
    chk("pre_pop3", pop_P, 4'b1000);
    step();
    chk("pre_out", Mux_out, 6'h07);
    almost_full_D1 = 1'b1;
    q0.push_back(6'b010101);
    q1.push_back(6'b000011);
    settle();
    chk("skip_pop1", pop_P, 4'b0010);
    step();
    chk("skip_out", Mux_out, 6'b000011);
    chk("skip_val", Mux_valid, 1'b1);
    chk("skip_blocked", pop_P, 4'h0);
    step();
    chk("skip_idle", idle, 1'b1);
    chk("skip_val0", Mux_valid, 1'b0);

    // Both destinations almost full, then release D0
    almost_full_D0 = 1'b1;
    q2.push_back(6'h0A);
    q3.push_back(6'h0B);
    settle();
    chk("af2_pop", pop_P, 4'h0);
    step();
    chk("af2_idle", idle, 1'b1);
    chk("af2_pop_b", pop_P, 4'h0);
    almost_full_D0 = 1'b0;
    settle();
    chk("af_rel_idle_pop", pop_P, 4'h0);
    step();
    chk("af_rel_pop2", pop_P, 4'b0100);
    step();
    chk("af_rel_out", Mux_out, 6'h0A);
    chk("af_rel_pop3", pop_P, 4'b1000);
    step();
    chk("af_rel_out2", Mux_out, 6'h0B);
    chk("af_d1_block", pop_P, 4'h0);
    almost_full_D1 = 1'b0;
    settle();
    chk("af_d1_rel", pop_P, 4'b0001);
    step();
    chk("af_d1_out", Mux_out, 6'h15);
    step();
    chk("af_end_idle", idle, 1'b1);

    // Enable drop: in-flight word delivered, then hold
    q1.push_back(6'h11);
    q2.push_back(6'h12);
    settle();
    step();
    chk("en_pop1", pop_P, 4'b0010);
    step();
    chk("en_out", Mux_out, 6'h11);
    chk("en_val", Mux_valid, 1'b1);
    enable = 1'b0;
    settle();
    chk("en_off_pop", pop_P, 4'h0);
    chk("en_cnt1", count_P1, 8'd3);
    step();
    chk("en_off_val", Mux_valid, 1'b0);
    chk("en_off_idle", idle, 1'b1);
    chk("en_off_cnt1", count_P1, 8'd3);
    enable = 1'b1;
    settle();
    step();
    chk("en_on_pop2", pop_P, 4'b0100);
    step();
    chk("en_on_out", Mux_out, 6'h12);
    step();

    // Reset pulse between edges
    #2;
    reset = 1'b1;
    #1;
    chk("rst2_val", Mux_valid, 1'b0);
    chk("rst2_cnt2", count_P2, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    settle();
    step();

    // Single busy port: 256 pops wrap its counter
    for (int i = 0; i < 256; i++) q2.push_back(6'(i));
    settle();
    n_pops = 0;
    first_cyc = -1;
    budget = 0;
    seen255 = 1'b0;
    while (q2.size() != 0 && budget < 400) begin
      step();
      budget++;
      if (n_pops == 100 && first_cyc == cyc - 99) begin
        chk("wrap_out100", Mux_out, 6'h23);
      end
      if (n_pops == 255 && !seen255) begin
        seen255 = 1'b1;
        chk("wrap_cnt255", count_P2, 8'd255);
      end
    end
    chk("wrap_budget", budget < 400, 1'b1);
    chk("wrap_pops", n_pops, 256);
    chk("wrap_burst", last_cyc - first_cyc, 255);
    chk("wrap_cnt2", count_P2, 8'd0);
    chk("wrap_cnt0", count_P0, 8'd0);
    chk("wrap_cnt1", count_P1, 8'd0);
    chk("wrap_cnt3", count_P3, 8'd0);

    // Asynchronous reset mid-stream
    q0.push_back(6'h21); q0.push_back(6'h22);
    q1.push_back(6'h24); q1.push_back(6'h25);
    settle();
    chk("ms_pop0", pop_P, 4'b0001);
    step();
    chk("ms_out", Mux_out, 6'h21);
    chk("ms_pop1", pop_P, 4'b0010);
    step();
    chk("ms_out2", Mux_out, 6'h24);
    #2;
    reset = 1'b1;
    #1;
    chk("ms_rst_val", Mux_valid, 1'b0);
    chk("ms_rst_out", Mux_out, 6'h00);
    chk("ms_rst_cnt0", count_P0, 8'd0);
    chk("ms_rst_cnt1", count_P1, 8'd0);
    chk("ms_rst_pop", pop_P, 4'h0);
    chk("ms_rst_idle", idle, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    settle();
    chk("ms_init_pop", pop_P, 4'h0);
    step();
    chk("ms_idle", idle, 1'b1);
    chk("ms_idle_pop", pop_P, 4'h0);
    step();
    chk("ms_ptr0_pop", pop_P, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
